// File: rtl/fw_pkg.sv
// Shared definitions for the blocked Floyd-Warshall tile scheduler.
// Phase encodings, FSM state type and parameter defaults.
package fw_pkg;

    localparam int NB_W_DEF    = 4;
    localparam int MAX_OUT_DEF = 2;

    localparam logic [1:0] PH_DIAG   = 2'b00;
    localparam logic [1:0] PH_ROWCOL = 2'b01;
    localparam logic [1:0] PH_DD     = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FIN
    } state_t;

endpackage

// File: rtl/fw_tile_iter.sv
// Walks the (phase, i, j) tiles of one phase group of round k.
// load selects the first tile of a group, adv steps to the next one.
module fw_tile_iter
    import fw_pkg::*;
#(
    parameter int NB_W = NB_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            adv,
    input  logic [1:0]      ld_phase,
    input  logic [NB_W-1:0] k,
    input  logic [NB_W:0]   n,
    output logic [1:0]      phase,
    output logic [NB_W-1:0] i,
    output logic [NB_W-1:0] j,
    output logic            last
);

    logic [NB_W-1:0] first;
    logic [NB_W:0]   ni;
    logic [NB_W:0]   nj;

    // Increment a coordinate, hopping over the pivot index k.
    function automatic logic [NB_W:0] skip_inc(
        input logic [NB_W-1:0] x,
        input logic [NB_W-1:0] kk
    );
        logic [NB_W:0] t;
        t = {1'b0, x} + 1'b1;
        if (t == {1'b0, kk}) t = t + 1'b1;
        return t;
    endfunction

    // Lowest index other than k, candidate successors and end-of-group flag.
    always_comb begin
        first    = '0;
        first[0] = (k == '0);
        ni       = skip_inc(i, k);
        nj       = skip_inc(j, k);
        last     = 1'b1;
        case (phase)
            PH_ROWCOL: last = (j == k) && (ni >= n);
            PH_DD:     last = (nj >= n) && (ni >= n);
            default:   last = 1'b1;
        endcase
    end

    // Group start on load; otherwise step row part, column part or row-major.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= PH_DIAG;
            i     <= '0;
            j     <= '0;
        end else if (load) begin
            phase <= ld_phase;
            case (ld_phase)
                PH_ROWCOL: begin
                    i <= k;
                    j <= first;
                end
                PH_DD: begin
                    i <= first;
                    j <= first;
                end
                default: begin
                    i <= k;
                    j <= k;
                end
            endcase
        end else if (adv) begin
            case (phase)
                PH_ROWCOL: begin
                    if (i == k) begin
                        if (nj < n) begin
                            j <= nj[NB_W-1:0];
                        end else begin
                            j <= k;
                            i <= first;
                        end
                    end else begin
                        i <= ni[NB_W-1:0];
                    end
                end
                PH_DD: begin
                    if (nj < n) begin
                        j <= nj[NB_W-1:0];
                    end else begin
                        j <= first;
                        i <= ni[NB_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fw_tile_sched.sv
// Blocked Floyd-Warshall tile scheduler: rounds, phase barriers,
// in-flight tile limit and valid/ready descriptor handshake.
module fw_tile_sched
    import fw_pkg::*;
#(
    parameter int NB_W    = NB_W_DEF,
    parameter int MAX_OUT = MAX_OUT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [NB_W:0]   num_blocks,
    output logic            tile_valid,
    input  logic            tile_ready,
    output logic [1:0]      tile_phase,
    output logic [NB_W-1:0] tile_i,
    output logic [NB_W-1:0] tile_j,
    output logic [NB_W-1:0] tile_k,
    input  logic            tile_done,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int OW = $clog2(MAX_OUT + 1);

    state_t          state;
    state_t          state_nxt;
    logic [NB_W:0]   n;
    logic [NB_W:0]   n_nxt;
    logic [NB_W-1:0] k;
    logic [NB_W-1:0] k_nxt;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   out_nxt;
    logic            err_nxt;
    logic            xfer;
    logic            cnt_dn;
    logic            stray;
    logic            load;
    logic            adv;
    logic            last;
    logic            last_round;
    logic [1:0]      ld_phase;

    assign tile_valid = (state == S_ISSUE) && (outstanding != OW'(MAX_OUT));
    assign xfer       = tile_valid && tile_ready;
    assign cnt_dn     = tile_done && ((outstanding != '0) || xfer);
    assign stray      = tile_done && (outstanding == '0) && !xfer;
    assign adv        = xfer && !last;
    assign last_round = ({1'b0, k} == n - 1'b1);
    assign busy       = (state == S_ISSUE) || (state == S_DRAIN);
    assign done       = (state == S_FIN);
    assign tile_k     = k;

    fw_tile_iter #(
        .NB_W(NB_W)
    ) u_iter (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .adv     (adv),
        .ld_phase(ld_phase),
        .k       (k_nxt),
        .n       (n_nxt),
        .phase   (tile_phase),
        .i       (tile_i),
        .j       (tile_j),
        .last    (last)
    );

    // In-flight tile count: up on transfer, down on writeback.
    always_comb begin
        out_nxt = outstanding;
        case ({xfer, cnt_dn})
            2'b10:   out_nxt = outstanding + 1'b1;
            2'b01:   out_nxt = outstanding - 1'b1;
            default: out_nxt = outstanding;
        endcase
    end

    // Run sequencing: group issue, barrier drain, skip of empty groups.
    always_comb begin
        state_nxt = state;
        n_nxt     = n;
        k_nxt     = k;
        load      = 1'b0;
        ld_phase  = PH_DIAG;
        err_nxt   = err | stray;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    n_nxt   = num_blocks;
                    k_nxt   = '0;
                    err_nxt = 1'b0;
                    if (num_blocks == '0) begin
                        state_nxt = S_FIN;
                    end else begin
                        load      = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (xfer && last) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_nxt == '0) begin
                    if (tile_phase == PH_DIAG && n != (NB_W+1)'(1)) begin
                        load      = 1'b1;
                        ld_phase  = PH_ROWCOL;
                        state_nxt = S_ISSUE;
                    end else if (tile_phase == PH_ROWCOL) begin
                        load      = 1'b1;
                        ld_phase  = PH_DD;
                        state_nxt = S_ISSUE;
                    end else if (last_round) begin
                        state_nxt = S_FIN;
                    end else begin
                        k_nxt     = k + 1'b1;
                        load      = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, run size, round index, in-flight count and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            n           <= '0;
            k           <= '0;
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            n           <= n_nxt;
            k           <= k_nxt;
            outstanding <= out_nxt;
            err         <= err_nxt;
        end
    end

endmodule

// File: tb/tb_fw_tile_sched.sv
// Self-checking bench for fw_tile_sched against a loop-built
// expected descriptor list and an in-flight tile count model.
module tb_fw_tile_sched;
    import fw_pkg::*;

    localparam int NB_W    = 4;
    localparam int MAX_OUT = 2;

    typedef struct packed {
        logic [1:0]      ph;
        logic [NB_W-1:0] i;
        logic [NB_W-1:0] j;
        logic [NB_W-1:0] k;
    } desc_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [NB_W:0]   num_blocks;
    logic            tile_valid;
    logic            tile_ready;
    logic [1:0]      tile_phase;
    logic [NB_W-1:0] tile_i;
    logic [NB_W-1:0] tile_j;
    logic [NB_W-1:0] tile_k;
    logic            tile_done;
    logic            busy;
    logic            done;
    logic            err;

    always #5 clk = ~clk;

    fw_tile_sched #(
        .NB_W   (NB_W),
        .MAX_OUT(MAX_OUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_blocks(num_blocks),
        .tile_valid(tile_valid),
        .tile_ready(tile_ready),
        .tile_phase(tile_phase),
        .tile_i    (tile_i),
        .tile_j    (tile_j),
        .tile_k    (tile_k),
        .tile_done (tile_done),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    desc_t exp_q[$];
    int    due_q[$];
    int    outst = 0;
    int    xfers = 0;
    int    dones = 0;
    int    ready_mode = 0;
    int    done_mode = 0;
    int    stall_cnt = 0;
    int    wait_cnt = 0;
    bit    hold_dones = 0;
    bit    force_done = 0;
    bit    busy_chk = 0;
    bit    prev_wait = 0;
    desc_t prev_d;
    bit    exp_err;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic desc_t mk(input logic [1:0] ph, input int i,
                                 input int j, input int k);
        desc_t d;
        d.ph = ph;
        d.i  = NB_W'(i);
        d.j  = NB_W'(j);
        d.k  = NB_W'(k);
        return d;
    endfunction

    // Expected issue order straight from the round/phase rules.
    function automatic void build(input int n);
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(mk(PH_DIAG, k, k, k));
            for (int j = 0; j < n; j++)
                if (j != k) exp_q.push_back(mk(PH_ROWCOL, k, j, k));
            for (int i = 0; i < n; i++)
                if (i != k) exp_q.push_back(mk(PH_ROWCOL, i, k, k));
            for (int i = 0; i < n; i++)
                for (int j = 0; j < n; j++)
                    if (i != k && j != k)
                        exp_q.push_back(mk(PH_DD, i, j, k));
        end
    endfunction

    task automatic tick();
        desc_t cur;
        bit    x;
        hold_dones = (done_mode == 2) && (xfers == 3) && (wait_cnt < 8);
        tile_done = force_done;
        if (!hold_dones) begin
            for (int q = 0; q < due_q.size(); q++) begin
                if (due_q[q] <= cyc) begin
                    due_q.delete(q);
                    tile_done = 1'b1;
                    break;
                end
            end
        end
        #1;
        case (ready_mode)
            1: tile_ready = 1'($urandom_range(0, 1));
            2: begin
                if (tile_valid && tile_phase == PH_ROWCOL && stall_cnt < 5) begin
                    tile_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    tile_ready = 1'b1;
                end
            end
            default: tile_ready = 1'b1;
        endcase
        #1;
        cur = {tile_phase, tile_i, tile_j, tile_k};
        if (outst >= MAX_OUT) chk("valid_at_max", 32'(tile_valid), 0);
        if (hold_dones) begin
            chk("valid_low_withheld", 32'(tile_valid), 0);
            wait_cnt++;
        end
        if (prev_wait) begin
            chk("hold_valid", 32'(tile_valid), 1);
            chk("hold_desc", 32'(cur), 32'(prev_d));
        end
        if (busy_chk) chk("busy", 32'(busy), done ? 0 : 1);
        x = tile_valid && tile_ready;
        if (x) begin
            chk("xfer_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("desc", 32'(cur), 32'(exp_q.pop_front()));
            xfers++;
            due_q.push_back(cyc + (done_mode == 1 ? int'($urandom_range(1, 4)) : 2));
        end
        if (done) dones++;
        prev_wait = tile_valid && !tile_ready;
        prev_d    = cur;
        if (x) outst++;
        if (tile_done && outst > 0) outst--;
        @(posedge clk);
        #1;
        chk("outstanding", 32'(dut.outstanding), outst);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n, input int rmode, input int dmode,
                       input bit poke);
        int lp;
        ready_mode = rmode;
        done_mode  = dmode;
        stall_cnt  = 0;
        wait_cnt   = 0;
        dones      = 0;
        xfers      = 0;
        build(n);
        num_blocks = (NB_W+1)'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_cleared", 32'(err), 0);
        busy_chk = (n > 0);
        lp = 0;
        while (dones == 0 && lp < 5000) begin
            if (poke && lp == 6) begin
                start = 1'b1;
                num_blocks = 1;
            end
            tick();
            start = 1'b0;
            lp++;
        end
        busy_chk = 0;
        chk("done_seen", dones, 1);
        chk("queue_empty", exp_q.size(), 0);
        chk("xfer_total", xfers, n * n * n);
        repeat (3) tick();
        chk("done_once", dones, 1);
        chk("busy_after", 32'(busy), 0);
        chk("err_end", 32'(err), 0);
    endtask

    initial begin
        int lp;
        reset = 1'b1;
        start = 1'b0;
        tile_ready = 1'b0;
        tile_done = 1'b0;
        num_blocks = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(tile_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_desc", 32'({tile_phase, tile_i, tile_j, tile_k}), 0);
        chk("rst_out", 32'(dut.outstanding), 0);
        reset = 1'b0;
        tick();

        run(2, 0, 0, 0);
        run(1, 0, 0, 0);
        run(0, 0, 0, 0);
        run(2, 2, 0, 0);
        chk("stall_cycles", stall_cnt, 5);
        run(3, 0, 2, 0);
        chk("withheld_cycles", wait_cnt, 8);

        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        chk("stray_err", 32'(err), 1);

        run(3, 1, 1, 1);
        for (int r = 0; r < 4; r++) run(int'($urandom_range(1, 5)), 1, 1, 0);

        ready_mode = 0;
        done_mode  = 0;
        xfers = 0;
        build(3);
        num_blocks = 3;
        start = 1'b1;
        tick();
        start = 1'b0;
        lp = 0;
        while (!(tile_valid === 1'b1 && tile_k == 1 && tile_phase == PH_DD
                 && outst > 0) && lp < 500) begin
            tick();
            lp++;
        end
        chk("reached_round1", 32'(tile_k), 1);
        exp_err = (due_q.size() > 0);
        dones = 0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc++;
        chk("mid_rst_valid", 32'(tile_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_err", 32'(err), 0);
        chk("mid_rst_desc", 32'({tile_phase, tile_i, tile_j, tile_k}), 0);
        exp_q.delete();
        outst = 0;
        prev_wait = 0;
        lp = 0;
        while (due_q.size() > 0 && lp < 20) begin
            tick();
            lp++;
        end
        chk("no_done_after_rst", dones, 0);
        chk("abandon_err", 32'(err), 32'(exp_err));
        run(2, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
